// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller between the pipeline MEM stage and a
// word-wide data memory. Sub-word loads are extracted and extended, sub-word
// stores are done as read-modify-write. Optional macro MISALIGN_TRAP_EN turns
// misaligned halfword/word accesses and the reserved size into faults that
// complete immediately with resp_err = 1.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  lane_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [31:0] wdata_reg;
  logic [31:0] mem_address_reg;
  logic [31:0] mem_write_data_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  logic        fault;
  logic [31:0] byte_shifted;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] byte_mask;
  logic [31:0] merged_word;

  // Address bits above the memory's reach are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  // Misaligned halfword/word or the reserved size faults at accept time.
  always_comb begin
    fault = (req_size == 2'b11) ||
            (req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end
`else
  assign fault = 1'b0;
`endif

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    byte_shifted = mem_read_data >> {lane_reg, 3'b000};
    load_half    = lane_reg[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (size_reg)
      2'b00:   load_ext = {{24{~unsigned_reg & byte_shifted[7]}}, byte_shifted[7:0]};
      2'b01:   load_ext = {{16{~unsigned_reg & load_half[15]}}, load_half};
      default: load_ext = mem_read_data;
    endcase
    byte_mask = 32'h0000_00FF << {lane_reg, 3'b000};
    if (size_reg == 2'b00) begin
      merged_word = (mem_read_data & ~byte_mask) |
                    ({24'h0, wdata_reg[7:0]} << {lane_reg, 3'b000});
    end else if (lane_reg[1]) begin
      merged_word = {wdata_reg[15:0], mem_read_data[15:0]};
    end else begin
      merged_word = {mem_read_data[31:16], wdata_reg[15:0]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (fault)                 state_next = RESP;
          else if (!req_we)          state_next = RD;
          else if (req_size[1] == 1'b0) state_next = RMW_RD;
          else                       state_next = WR;
        end
      end
      RD:      state_next = RESP;
      RMW_RD:  state_next = WR;
      WR:      state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch at accept, load result capture and merged-word capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_reg           <= 2'b00;
      size_reg           <= 2'b00;
      unsigned_reg       <= 1'b0;
      wdata_reg          <= 32'h0;
      mem_address_reg    <= 32'h0;
      mem_write_data_reg <= 32'h0;
      resp_rdata_reg     <= 32'h0;
      resp_err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            lane_reg           <= req_addr[1:0];
            size_reg           <= req_size;
            unsigned_reg       <= req_unsigned;
            wdata_reg          <= req_wdata;
            mem_address_reg    <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
            mem_write_data_reg <= (req_we && req_size[1]) ? req_wdata : 32'h0;
            resp_rdata_reg     <= 32'h0;
            resp_err_reg       <= fault;
          end
        end
        RD:      resp_rdata_reg     <= load_ext;
        RMW_RD:  mem_write_data_reg <= merged_word;
        default: ;
      endcase
    end
  end

  assign req_ready      = (state_reg == IDLE);
  assign resp_valid     = (state_reg == RESP);
  assign mem_read       = (state_reg == RD) || (state_reg == RMW_RD);
  assign mem_write      = (state_reg == WR);
  assign mem_address    = mem_address_reg;
  assign mem_write_data = mem_write_data_reg;
  assign resp_rdata     = resp_rdata_reg;
  assign resp_err       = resp_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed test-plan steps followed by random
// transactions, checked against a word-array reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  int compared = 0;
  int fails    = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int txn_no   = 0;
  logic mon_en = 1'b0;
  logic mem_init;

  logic [31:0] tb_mem  [0:1023];
  logic [31:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Data memory: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
    end else if (mem_write) begin
      tb_mem[mem_address[9:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = tb_mem[mem_address[9:0]];

  // Strobe monitor: counts pulses and checks strobe exclusivity every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      compared++;
      assert (!(mem_read && mem_write)) else begin
        fails++;
        $error("FAIL strobe_both: observed rd=%0b wr=%0b required not both", mem_read, mem_write);
      end
      compared++;
      assert (!((req_ready || resp_valid) && (mem_read || mem_write))) else begin
        fails++;
        $error("FAIL strobe_idle_resp: observed rd=%0b wr=%0b required 0 in IDLE/RESP", mem_read, mem_write);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one access to ref_mem and predicts the outcome.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err,
                            output int lat, output int nrd, output int nwr);
    logic [31:0] old, v;
    int widx, sh8, sh16;
    logic flt;
    widx = int'(addr[11:2]);
    old  = ref_mem[widx];
    sh8  = 8 * int'(addr[1:0]);
    sh16 = 16 * int'(addr[1]);
    flt  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    flt = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`endif
    rdata = 32'h0; err = 1'b0;
    if (flt) begin
      err = 1'b1; lat = 1; nrd = 0; nwr = 0;
    end else if (!we) begin
      lat = 2; nrd = 1; nwr = 0;
      if (size == 2'd0) begin
        v = (old >> sh8) & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        rdata = v;
      end else if (size == 2'd1) begin
        v = (old >> sh16) & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
        rdata = v;
      end else begin
        rdata = old;
      end
    end else if (size == 2'd0) begin
      lat = 3; nrd = 1; nwr = 1;
      ref_mem[widx] = (old & ~(32'hFF << sh8)) | ((wdata & 32'hFF) << sh8);
    end else if (size == 2'd1) begin
      lat = 3; nrd = 1; nwr = 1;
      ref_mem[widx] = (old & ~(32'hFFFF << sh16)) | ((wdata & 32'hFFFF) << sh16);
    end else begin
      lat = 2; nrd = 0; nwr = 1;
      ref_mem[widx] = wdata;
    end
  endtask

  // One full transaction: handshake, latency, result, optional backpressure.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, output logic [31:0] got);
    logic [31:0] e_rdata;
    logic e_err;
    int e_lat, e_nrd, e_nwr, lat, r0, w0;
    ref_access(we, size, uns, addr, wdata, e_rdata, e_err, e_lat, e_nrd, e_nwr);
    check("req_ready_before", {31'b0, req_ready}, 32'd1);
    r0 = rd_cnt; w0 = wr_cnt;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr;
    req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    check("mem_address", mem_address, {22'b0, addr[11:2]});
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("resp_valid_arrives", {31'b0, resp_valid}, 32'd1);
    check("latency", lat, e_lat);
    check("resp_rdata", resp_rdata, e_rdata);
    check("resp_err", {31'b0, resp_err}, {31'b0, e_err});
    got = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, e_rdata);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_address", mem_address, {22'b0, addr[11:2]});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("after_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("after_req_ready", {31'b0, req_ready}, 32'd1);
    check("read_pulses", rd_cnt - r0, e_nrd);
    check("write_pulses", wr_cnt - w0, e_nwr);
    $display("txn %0d we=%0b size=%0d uns=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d hold=%0d",
             txn_no, we, size, uns, addr, wdata, got, resp_err, lat, hold);
    txn_no++;
  endtask

  initial begin
    logic [31:0] got;
    rst_n = 1'b0; mem_init = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; mem_init = 1'b0; mon_en = 1'b1;

    // Reset state
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_write_data", mem_write_data, 32'h0);

    // Signed/unsigned sub-word loads
    run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_7F80, 0, got);
    run_txn(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, got);
    check("lb_const", got, 32'hFFFF_FF80);
    run_txn(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0, got);
    check("lbu_const", got, 32'h0000_0080);
    run_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, got);
    check("lh_const", got, 32'hFFFF_8000);

    // Sub-word store merge
    run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 0, got);
    run_txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 0, got);
    run_txn(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, 0, got);
    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
    check("merge_const", got, 32'hBEEF_AB44);

    // Response backpressure
    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, got);

    // Misaligned word load
    run_txn(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, got);
`ifdef MISALIGN_TRAP_EN
    check("misalign_const", got, 32'h0);
`else
    check("misalign_const", got, 32'hBEEF_AB44);
`endif

    // Reset during RMW_RD abandons the store
    run_txn(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 0, got);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_rd_reading", {31'b0, mem_read}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rmwrst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rmwrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rmwrst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rmwrst_mem_write", {31'b0, mem_write}, 32'd0);
    $display("txn %0d reset during RMW_RD of SB addr=00000041", txn_no);
    txn_no++;
    run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, got);
    check("rmwrst_word_kept", got, 32'hCAFE_F00D);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom, $urandom,
              int'($urandom_range(0, 3)), got);
    end

    // Final memory image
    for (int i = 0; i < 1024; i++) check("final_mem", tb_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule
